mp_add_seq: RTL and testbench
=============================

# mp_add_seq

Multi-precision adder sequencer. Accepts two WORDS-byte operands over a valid/ready handshake and streams them LSB byte first through a single 8-bit carry-select adder slice, chaining the carry between cycles. It returns the full-width sum, carry-out and signed-overflow flag over a second valid/ready handshake. It is the control wrapper that lets one 8-bit adder serve arbitrary-width additions in the arithmetic datapath.

## Interface
- WORDS, default 4: operand width in bytes; legal range 1..16; total width W = 8*WORDS
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand bundle valid
- in_ready  out  1  block can accept a bundle (IDLE only)
- a  in  W  operand A, sampled on input handshake
- b  in  W  operand B, sampled on input handshake
- cin  in  1  carry-in, sampled on input handshake
- sub  in  1  subtract request (present only with MP_ADD_SUB_EN)
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  consumer accepts result
- sum  out  W  result, stable while out_valid
- cout  out  1  carry out of bit W-1
- ovf  out  1  two's-complement overflow: a[W-1] ^ b_eff[W-1] ^ sum[W-1] ^ cout
- busy  out  1  high in RUN or DONE

## Operation
- FSM states: IDLE, RUN, DONE; reset state IDLE
- IDLE: in_ready=1; on in_valid&in_ready, latch a, b (b_eff), cin into operand registers, clear byte index idx and sum register, load carry register with cin, go to RUN
- RUN: slice adds a[8*idx+:8] + b_eff[8*idx+:8] + carry; result byte written to sum[8*idx+:8], slice carry-out written to carry register; idx increments; after byte WORDS-1 go to DONE
- DONE: out_valid=1; cout = final carry register; ovf computed from latched MSBs; on out_ready go to IDLE
- in_valid outside IDLE ignored (in_ready=0); no input is lost because no handshake occurs
- idx counter width max(1, $clog2(WORDS)); no wrap past WORDS-1 (transition to DONE takes precedence)
- All arithmetic modulo 2^W; cout carries the bit-W result

## Timing
- Reset values: in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, busy=0
- Input handshake in cycle T; bytes processed at edges ending cycles T+1..T+WORDS; out_valid asserted from cycle T+WORDS+1
- Latency WORDS+1 cycles handshake-to-out_valid; throughput one op per WORDS+2 cycles with out_ready held high
- out_valid, sum, cout and ovf are held stable while out_ready=0, for any number of cycles
- Result handshake in cycle R: in_ready=1 in cycle R+1; no same-cycle input acceptance in DONE
- rst asserted in any state, including mid-RUN: immediate return to IDLE, all registers cleared, partial result discarded, out_valid never pulses
- WORDS=1: single RUN cycle; out_valid from T+2

## Configuration
- MP_ADD_SUB_EN defined: sub port exists; when sub=1 at handshake, b_eff = ~b and initial carry = ~cin (borrow-in convention: cin=0 gives a-b, cin=1 gives a-b-1); cout=1 means no borrow
- MP_ADD_SUB_EN undefined: no sub port; b_eff = b, initial carry = cin

## Structure
- Package mp_add_pkg: state enum type (IDLE, RUN, DONE), BYTE_W=8 constant, WORDS_MAX=16 constant
- One sub-module, byte_csa: purely combinational 8-bit carry-select adder slice (a, b, cin -> sum, cout); precomputes both carry-in cases and muxes on cin
- All sequencing, registers and flags live in mp_add_seq

## Test plan
- WORDS=4, a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, ovf=0, out_valid at T+5
- a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1; a=0x12345678, b=0x11111111, cin=1 -> sum=0x2345678A
- out_ready held low 10 cycles in DONE -> sum/cout/ovf stable, in_ready=0, in_valid pulses ignored; release -> in_ready=1 next cycle
- rst asserted at T+2 mid-RUN -> all outputs at reset values same cycle; next bundle computes correctly from clean state
- MP_ADD_SUB_EN, sub=1, cin=0: a=0x00000005, b=0x00000007 -> sum=0xFFFFFFFE, cout=0; a=7, b=5 -> sum=2, cout=1
- WORDS=1, a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, ovf=1, out_valid at T+2; back-to-back bundles with out_ready=1 accepted every 3 cycles

Source files
------------

// File: rtl/mp_add_pkg.sv
// Shared types and constants for the multi-precision adder sequencer.
package mp_add_pkg;

    localparam int BYTE_W    = 8;
    localparam int WORDS_MAX = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/mp_add_seq_byte_csa.sv
// 8-bit carry-select adder slice: both carry-in results are formed up front
// and the incoming carry only drives the final mux.
module byte_csa
    import mp_add_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    logic [BYTE_W:0] sum_c0;
    logic [BYTE_W:0] sum_c1;

    always_comb begin
        sum_c0 = {1'b0, a} + {1'b0, b};
        sum_c1 = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, 1'b1};
        if (cin) begin
            {cout, sum} = sum_c1;
        end else begin
            {cout, sum} = sum_c0;
        end
    end

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision adder sequencer: streams WORDS bytes LSB-first through one
// byte_csa slice. Define MP_ADD_SUB_EN to add the sub port (borrow-in subtract).
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BYTE_W*WORDS-1:0] a,
    input  logic [BYTE_W*WORDS-1:0] b,
    input  logic                    cin,
`ifdef MP_ADD_SUB_EN
    input  logic                    sub,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BYTE_W*WORDS-1:0] sum,
    output logic                    cout,
    output logic                    ovf,
    output logic                    busy
);

    localparam int W     = BYTE_W * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [W-1:0]      b_eff;
    logic              carry_init;
    logic [BYTE_W-1:0] a_byte;
    logic [BYTE_W-1:0] b_byte;
    logic [BYTE_W-1:0] slice_sum;
    logic              slice_cout;

`ifdef MP_ADD_SUB_EN
    always_comb begin
        b_eff      = sub ? ~b : b;
        carry_init = sub ? ~cin : cin;
    end
`else
    always_comb begin
        b_eff      = b;
        carry_init = cin;
    end
`endif

    always_comb begin
        a_byte = '0;
        b_byte = '0;
        for (int unsigned i = 0; i < WORDS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_byte = a_q[i*BYTE_W +: BYTE_W];
                b_byte = b_q[i*BYTE_W +: BYTE_W];
            end
        end
    end

    byte_csa u_csa (
        .a    (a_byte),
        .b    (b_byte),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b_eff;
                    carry_d = carry_init;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int unsigned i = 0; i < WORDS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[i*BYTE_W +: BYTE_W] = slice_sum;
                    end
                end
                carry_d = slice_cout;
                // Leaving for DONE wins over the increment, so idx never wraps.
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = carry_q;
    // b_q already holds b_eff, so this covers subtraction too.
    assign ovf       = a_q[W-1] ^ b_q[W-1] ^ sum_q[W-1] ^ carry_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Scoreboard bench for mp_add_seq: a WORDS=4 instance for the main scenarios
// and a WORDS=1 instance for the single-byte boundary case.
module tb_mp_add_seq;

    localparam int W  = 32;
    localparam int W1 = 8;
`ifdef MP_ADD_SUB_EN
    localparam bit SUB_ON = 1'b1;
`else
    localparam bit SUB_ON = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         in_valid = 1'b0, out_ready = 1'b1, cin = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         in_ready, out_valid, cout, ovf, busy;
    logic [W-1:0] sum;
`ifdef MP_ADD_SUB_EN
    logic         sub = 1'b0;
    logic         sub1 = 1'b0;
`endif

    logic          in_valid1 = 1'b0, out_ready1 = 1'b1, cin1 = 1'b0;
    logic [W1-1:0] a1 = '0, b1 = '0;
    logic          in_ready1, out_valid1, cout1, ovf1, busy1;
    logic [W1-1:0] sum1;

    mp_add_seq #(.WORDS(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef MP_ADD_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .ovf(ovf), .busy(busy)
    );

    mp_add_seq #(.WORDS(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1),
`ifdef MP_ADD_SUB_EN
        .sub(sub1),
`endif
        .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1),
        .cout(cout1), .ovf(ovf1), .busy(busy1)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: returns {ovf, cout, sum[63:0]} for an n-bit add/subtract.
    function automatic logic [65:0] model(input int unsigned n, input logic [63:0] x,
                                          input logic [63:0] y, input logic ci, input logic s);
        logic [63:0] mask, ye, r;
        logic [64:0] full;
        logic        c0, co, ov;
        mask = (64'd1 << n) - 64'd1;
        ye   = (s ? ~y : y) & mask;
        c0   = s ? ~ci : ci;
        full = {1'b0, x & mask} + {1'b0, ye} + {64'd0, c0};
        co   = full[n];
        r    = full[63:0] & mask;
        ov   = (x[n-1] == ye[n-1]) && (r[n-1] != x[n-1]);
        return {ov, co, r};
    endfunction

    exp_t exp_q[$];
    int   hs_q[$];
    bit   prev_ov = 1'b0, b2b = 1'b0, have_prev = 1'b0;
    int   last_hs = 0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) begin
                if (b2b && have_prev) check("b2b_gap", 64'(cyc - last_hs), 64'(6));
                last_hs   = cyc;
                have_prev = 1'b1;
                hs_q.push_back(cyc);
            end
            if (out_valid && !prev_ov) begin
                if (hs_q.size() == 0) check("spurious_valid", 64'd1, 64'd0);
                else check("latency", 64'(cyc - hs_q[0]), 64'(5));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (hs_q.size() != 0) void'(hs_q.pop_front());
                    check("sum", 64'(sum), 64'(mon_e.sum));
                    check("cout", 64'(cout), 64'(mon_e.cout));
                    check("ovf", 64'(ovf), 64'(mon_e.ovf));
                end
            end
            prev_ov = out_valid;
        end
    end

    logic [9:0] exp1_q[$];
    int         hs1_q[$];
    bit         prev1 = 1'b0, have1 = 1'b0;
    int         last1 = 0;
    logic [65:0] r1;
    logic [9:0]  e1;

    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid1 && in_ready1) begin
                r1 = model(W1, 64'(a1), 64'(b1), cin1, 1'b0);
                exp1_q.push_back({r1[65], r1[64], r1[7:0]});
                if (have1) check("w1_gap", 64'(cyc - last1), 64'(3));
                last1 = cyc;
                have1 = 1'b1;
                hs1_q.push_back(cyc);
            end
            if (out_valid1 && !prev1) begin
                if (hs1_q.size() == 0) check("w1_spurious_valid", 64'd1, 64'd0);
                else check("w1_latency", 64'(cyc - hs1_q[0]), 64'(2));
            end
            if (out_valid1 && out_ready1) begin
                if (exp1_q.size() == 0) begin
                    check("w1_spurious_out", 64'd1, 64'd0);
                end else begin
                    e1 = exp1_q.pop_front();
                    if (hs1_q.size() != 0) void'(hs1_q.pop_front());
                    check("w1_result", 64'({ovf1, cout1, sum1}), 64'(e1));
                end
            end
            prev1 = out_valid1;
        end
    end

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc, input logic ts);
        logic [65:0] r;
        exp_t        e;
        bit          ok;
        @(posedge clk);
        #1;
        r      = model(W, 64'(ta), 64'(tb_), tc, ts & SUB_ON);
        e.sum  = r[W-1:0];
        e.cout = r[64];
        e.ovf  = r[65];
        a      = ta;
        b      = tb_;
        cin    = tc;
`ifdef MP_ADD_SUB_EN
        sub    = ts;
`endif
        in_valid = 1'b1;
        exp_q.push_back(e);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && exp1_q.size() == 0) break;
        end
        check("drain", 64'(exp_q.size() + exp1_q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t se;
        int   pulses;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout_ovf_busy", 64'({cout, ovf, busy}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        drain();

`ifdef MP_ADD_SUB_EN
        send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
        send(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1);
        send(32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1);
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        drain();
`endif

        // Back-to-back random bundles with out_ready held high.
        b2b       = 1'b1;
        have_prev = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain();
        b2b = 1'b0;

        // Result held while the consumer stalls; input pulses must be ignored.
        out_ready = 1'b0;
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check("stall_reach_done", 64'(out_valid), 64'd1);
        se.sum = '0; se.cout = 1'b0; se.ovf = 1'b0;
        if (exp_q.size() != 0) se = exp_q[0];
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_valid = (i % 2 == 1);
            a        = $urandom;
            @(negedge clk);
            check("stall_hold", 64'({out_valid, in_ready, ovf, cout, sum}),
                  64'({1'b1, 1'b0, se.ovf, se.cout, se.sum}));
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("done_no_accept", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("release_ready", 64'(in_ready), 64'd1);
        drain();

        // Reset in the middle of RUN discards the partial result.
        send(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_sum", 64'(sum), 64'd0);
        check("midrst_cout_ovf_busy", 64'({cout, ovf, busy}), 64'd0);
        exp_q.delete();
        hs_q.delete();
        prev_ov = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("midrst_no_pulse", 64'(pulses), 64'd0);
        send(32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0, 1'b0);
        drain();

        // WORDS=1 instance: 0x80+0x80 first, then random back-to-back bundles.
        @(posedge clk);
        #1;
        a1 = 8'h80;
        b1 = 8'h80;
        cin1 = 1'b0;
        in_valid1 = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 12; i++) begin
            a1   = 8'($urandom);
            b1   = 8'($urandom);
            cin1 = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        in_valid1 = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
